// File: rtl/divisor_pkg.sv
// Shared types and constants for the multi-channel clock divider.
// The output mode enum and channel-select width helper live here.
package divisor_pkg;

   typedef enum logic {
      MODE_TOGGLE = 1'b0,
      MODE_PULSE  = 1'b1
   } mode_t;

   localparam int DEFAULT_DIV_C = 50000;

   // Channel-select width: clog2 of the channel count, never below one bit.
   function automatic int CH_W(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/divisor_canal.sv
// One divider channel: wrap counter, active/pending divisor, registered outputs.
// A pending divisor is applied only at a wrap or while disabled, so periods are never truncated.
module divisor_canal
   import divisor_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = DEFAULT_DIV_C
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             enable,
   input  logic             mode,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_val,
   output logic             clk_out,
   output logic             tick
);

   localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] div_q;
   logic [WIDTH-1:0] div_p;
   logic             pend;
   mode_t            mode_sel;
   logic             wrap;
   logic             apply;

   assign mode_sel = mode_t'(mode);
   assign wrap     = enable && (cnt == div_q);
   assign apply    = !enable || wrap;

   always_ff @(posedge clk_in) begin
      if (!reset) begin
         cnt     <= '0;
         div_q   <= DEF_DIV;
         div_p   <= DEF_DIV;
         pend    <= 1'b0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else begin
         if (!enable) begin
            cnt     <= '0;
            tick    <= 1'b0;
            clk_out <= (mode_sel == MODE_PULSE) ? 1'b0 : clk_out;
         end else if (wrap) begin
            cnt     <= '0;
            tick    <= 1'b1;
            clk_out <= (mode_sel == MODE_PULSE) ? 1'b1 : ~clk_out;
         end else begin
            cnt     <= cnt + 1'b1;
            tick    <= 1'b0;
            clk_out <= (mode_sel == MODE_PULSE) ? 1'b0 : clk_out;
         end

         if (apply) begin
            if (pend) begin
               div_q <= div_p;
            end
            pend <= 1'b0;
         end

         // A write landing on the apply cycle wins the pend flag and waits for the next wrap.
         if (wr) begin
            div_p <= wr_val;
            pend  <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/divisor_reloj_multi.sv
// N_CH independent programmable clock dividers sharing one divisor write port.
// The top decodes the write channel and returns a registered acknowledge.
module divisor_reloj_multi
   import divisor_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = DEFAULT_DIV_C
) (
   input  logic                     clk_in,
   input  logic                     reset,
   input  logic [N_CH-1:0]          enable,
   input  logic [N_CH-1:0]          mode,
   input  logic                     div_wr,
   input  logic [CH_W(N_CH)-1:0]    div_ch,
   input  logic [WIDTH-1:0]         div_val,
   output logic                     div_ack,
   output logic [N_CH-1:0]          clk_out,
   output logic [N_CH-1:0]          tick
);

   localparam int CHW = CH_W(N_CH);

   // Write handshake: div_wr is a one-cycle request with no back-pressure; a write
   // addressing an existing channel is always taken and answered by div_ack one cycle later.
   logic wr_ok;

   assign wr_ok = div_wr && (int'(div_ch) < N_CH);

   always_ff @(posedge clk_in) begin
      if (!reset) begin
         div_ack <= 1'b0;
      end else begin
         div_ack <= wr_ok;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      divisor_canal #(
         .WIDTH       (WIDTH),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_canal (
         .clk_in  (clk_in),
         .reset   (reset),
         .enable  (enable[i]),
         .mode    (mode[i]),
         .wr      (wr_ok && (div_ch == CHW'(i))),
         .wr_val  (div_val),
         .clk_out (clk_out[i]),
         .tick    (tick[i])
      );
   end

endmodule

// File: tb/tb_divisor_reloj_multi.sv
// Randomized bench for divisor_reloj_multi against a countdown-based reference model.
// Outputs are compared every falling edge after the model absorbs the inputs of the last rising edge.
module tb_divisor_reloj_multi;

   localparam int N_CH        = 3;
   localparam int WIDTH       = 16;
   localparam int DEFAULT_DIV = 4;
   localparam int CHW         = 2;

   logic              clk_in = 1'b0;
   logic              reset;
   logic [N_CH-1:0]   enable;
   logic [N_CH-1:0]   mode;
   logic              div_wr;
   logic [CHW-1:0]    div_ch;
   logic [WIDTH-1:0]  div_val;
   logic              div_ack;
   logic [N_CH-1:0]   clk_out;
   logic [N_CH-1:0]   tick;

   int vectors     = 0;
   int miscompares = 0;
   int cycle_no    = 0;

   // Model: each channel is described by cycles remaining until its next wrap.
   int   m_div  [N_CH];
   int   m_divp [N_CH];
   bit   m_pend [N_CH];
   int   m_rem  [N_CH];
   bit   m_clk  [N_CH];
   bit   m_tick [N_CH];
   bit   m_ack;
   bit   model_ok = 1'b0;

   divisor_reloj_multi #(
      .N_CH        (N_CH),
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) dut (
      .clk_in  (clk_in),
      .reset   (reset),
      .enable  (enable),
      .mode    (mode),
      .div_wr  (div_wr),
      .div_ch  (div_ch),
      .div_val (div_val),
      .div_ack (div_ack),
      .clk_out (clk_out),
      .tick    (tick)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cycle_no, got, exp);
      end
   endtask

   task automatic model_step();
      if (!reset) begin
         for (int c = 0; c < N_CH; c++) begin
            m_div[c]  = DEFAULT_DIV;
            m_divp[c] = DEFAULT_DIV;
            m_pend[c] = 1'b0;
            m_rem[c]  = DEFAULT_DIV;
            m_clk[c]  = 1'b0;
            m_tick[c] = 1'b0;
         end
         m_ack    = 1'b0;
         model_ok = 1'b1;
      end else begin
         m_ack = div_wr && (int'(div_ch) < N_CH);
         for (int c = 0; c < N_CH; c++) begin
            if (!enable[c]) begin
               if (m_pend[c]) m_div[c] = m_divp[c];
               m_pend[c] = 1'b0;
               m_rem[c]  = m_div[c];
               m_tick[c] = 1'b0;
               if (mode[c]) m_clk[c] = 1'b0;
            end else if (m_rem[c] == 0) begin
               if (m_pend[c]) m_div[c] = m_divp[c];
               m_pend[c] = 1'b0;
               m_rem[c]  = m_div[c];
               m_tick[c] = 1'b1;
               m_clk[c]  = mode[c] ? 1'b1 : ~m_clk[c];
            end else begin
               m_rem[c]  = m_rem[c] - 1;
               m_tick[c] = 1'b0;
               if (mode[c]) m_clk[c] = 1'b0;
            end
            if (div_wr && int'(div_ch) == c) begin
               m_divp[c] = int'(div_val);
               m_pend[c] = 1'b1;
            end
         end
      end
   endtask

   task automatic step();
      logic [N_CH-1:0] exp_tick;
      logic [N_CH-1:0] exp_clk;
      @(negedge clk_in);
      cycle_no++;
      model_step();
      if (model_ok) begin
         for (int c = 0; c < N_CH; c++) begin
            exp_tick[c] = m_tick[c];
            exp_clk[c]  = m_clk[c];
         end
         check("tick", 32'(tick), 32'(exp_tick));
         check("clk_out", 32'(clk_out), 32'(exp_clk));
         check("div_ack", 32'(div_ack), 32'(m_ack));
      end
   endtask

   task automatic write(input int ch, input int val);
      div_wr  = 1'b1;
      div_ch  = CHW'(ch);
      div_val = WIDTH'(val);
      step();
      div_wr  = 1'b0;
   endtask

   initial begin
      reset   = 1'b0;
      enable  = '0;
      mode    = '0;
      div_wr  = 1'b0;
      div_ch  = '0;
      div_val = '0;
      repeat (3) step();

      // Default divisor, toggle mode on every channel.
      reset  = 1'b1;
      enable = '1;
      repeat (40) step();

      // Pulse mode with zero divisor, then reprogram to 2.
      mode = '1;
      write(0, 0);
      repeat (12) step();
      write(0, 2);
      repeat (12) step();

      // Deferred writes and an overwrite before the wrap.
      mode = '0;
      write(1, 9);
      repeat (20) step();
      write(1, 7);
      write(1, 1);
      repeat (30) step();

      // Invalid channel write.
      write(3, 1);
      repeat (10) step();

      // Randomized traffic including mid-run resets.
      for (int n = 0; n < 4000; n++) begin
         reset = ($urandom_range(0, 299) != 0);
         for (int c = 0; c < N_CH; c++) begin
            if ($urandom_range(0, 49) == 0) enable[c] = ~enable[c];
            if ($urandom_range(0, 59) == 0) mode[c]   = ~mode[c];
         end
         div_wr = ($urandom_range(0, 7) == 0);
         div_ch = CHW'($urandom_range(0, 3));
         if ($urandom_range(0, 39) == 0)
            div_val = WIDTH'($urandom_range(0, 65535));
         else
            div_val = WIDTH'($urandom_range(0, 9));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
